// File: rtl/stream_join_dynamic_if.sv
// -----------------------------------------------------------------------------
// stream_join_dynamic_if
// Handshake bundle for stream_join_dynamic. There are no data lanes; only the
// valid/ready pairs of the N_INP input streams, the join-mask stream and the
// joined output stream, plus the join counter.
//
// Signals (named from the join block's point of view):
//   valid_i     [N_INP]  per-input-stream valid            (upstream -> join)
//   ready_o     [N_INP]  per-input-stream ready            (join -> upstream)
//   sel_i       [N_INP]  join mask, bit i = input i joins  (upstream -> join)
//   sel_valid_i          join mask valid                   (upstream -> join)
//   sel_ready_o          join mask ready                   (join -> upstream)
//   valid_o              joined output valid               (join -> downstream)
//   ready_i              joined output ready               (downstream -> join)
//   join_cnt_o  [32]     completed-join count              (join -> observer)
//
// Modports:
//   slave  - the join block itself
//   master - the environment driving it (upstream, downstream, observer)
// -----------------------------------------------------------------------------
interface stream_join_dynamic_if #(
    parameter int N_INP = 0
);
    logic [N_INP-1:0] valid_i;
    logic [N_INP-1:0] ready_o;
    logic [N_INP-1:0] sel_i;
    logic             sel_valid_i;
    logic             sel_ready_o;
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      join_cnt_o;

    modport slave (
        input  valid_i,
        input  sel_i,
        input  sel_valid_i,
        input  ready_i,
        output ready_o,
        output sel_ready_o,
        output valid_o,
        output join_cnt_o
    );

    modport master (
        output valid_i,
        output sel_i,
        output sel_valid_i,
        output ready_i,
        input  ready_o,
        input  sel_ready_o,
        input  valid_o,
        input  join_cnt_o
    );
endinterface

// File: rtl/stream_join_dynamic.sv
// -----------------------------------------------------------------------------
// stream_join_dynamic
// Handshake-only join of a dynamically selected subset of N_INP input streams.
// A join mask (sel_i, qualified by sel_valid_i) names the inputs taking part.
// Each selected input handshakes exactly once; the arrived register remembers
// which ones already did.  The output is valid once every selected input has
// either arrived earlier or is valid now, so a fully-valid join completes with
// zero latency.  The mask is consumed on the output handshake, which also
// clears the arrived register.
//
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset (clears arrived bits and counter)
//   bus    - stream_join_dynamic_if.slave (see interface file for members)
//
// Parameter:
//   N_INP  - number of input streams, must be >= 1 (elaboration stops otherwise)
//
// Build option:
//   STREAM_JOIN_DYNAMIC_CNT_EN - when defined, join_cnt_o counts output
//   handshakes (wrapping modulo 2^32); when undefined, join_cnt_o is tied to 0
//   and no counter register is built.
// -----------------------------------------------------------------------------
module stream_join_dynamic #(
    parameter int N_INP = 0
) (
    input logic                  clk_i,
    input logic                  rst_i,
    stream_join_dynamic_if.slave bus
);

    if (N_INP < 1) begin : g_bad_param
        $fatal(1, "stream_join_dynamic: N_INP must be at least 1");
    end

    logic [N_INP-1:0] r_arrived;   // input i has handshaked in the current join
    logic [N_INP-1:0] w_ready;
    logic [N_INP-1:0] w_term;      // input i does not block the output
    logic [N_INP-1:0] w_in_hs;
    logic             w_valid_o;
    logic             w_out_hs;

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_lane
        // Ready never looks at ready_i, so upstream can't form a loop through
        // the downstream path.
        assign w_ready[gi] = bus.sel_valid_i & bus.sel_i[gi] & ~r_arrived[gi];
        assign w_term[gi]  = ~bus.sel_i[gi] | r_arrived[gi] | bus.valid_i[gi];
        assign w_in_hs[gi] = bus.valid_i[gi] & w_ready[gi];
    end

    // An empty mask makes every term true, so the join fires on the mask alone.
    assign w_valid_o = bus.sel_valid_i & (&w_term);
    assign w_out_hs  = w_valid_o & bus.ready_i;

    assign bus.ready_o     = w_ready;
    assign bus.valid_o     = w_valid_o;
    assign bus.sel_ready_o = w_out_hs;

    // Completion wins over same-cycle arrivals: inputs that handshake in the
    // completing cycle belong to the join that just finished.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_arrived <= '0;
        end else if (w_out_hs) begin
            r_arrived <= '0;
        end else begin
            r_arrived <= r_arrived | w_in_hs;
        end
    end

`ifdef STREAM_JOIN_DYNAMIC_CNT_EN
    logic [31:0] r_join_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_join_cnt <= '0;
        end else if (w_out_hs) begin
            r_join_cnt <= r_join_cnt + 32'd1;   // natural wrap at 2^32
        end
    end

    assign bus.join_cnt_o = r_join_cnt;
`else
    assign bus.join_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
    // Upstream protocol checks.
    a_sel_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (bus.sel_valid_i && !bus.sel_ready_o) |=> $stable(bus.sel_i)
    ) else $error("stream_join_dynamic: sel_i changed while waiting for sel_ready_o");

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_vld_chk
        a_valid_hold: assert property (
            @(posedge clk_i) disable iff (rst_i)
            (bus.valid_i[gi] && !bus.ready_o[gi]) |=> bus.valid_i[gi]
        ) else $error("stream_join_dynamic: valid_i[%0d] dropped before its handshake", gi);
    end
`endif

endmodule

// File: tb/tb_stream_join_dynamic.sv
// -----------------------------------------------------------------------------
// tb_stream_join_dynamic
// Directed bench for stream_join_dynamic with N_INP = 4.  Each step drives one
// cycle of stimulus and pushes the expected combinational outputs onto a
// scoreboard queue; the entry is popped and compared at the following falling
// edge.  The expected join count is tracked by the bench from the expected
// output handshakes (it stays 0 unless STREAM_JOIN_DYNAMIC_CNT_EN is defined).
// -----------------------------------------------------------------------------
module tb_stream_join_dynamic;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stream_join_dynamic_if #(.N_INP(N)) bus ();

    stream_join_dynamic #(.N_INP(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] rdy;
        logic         vld;
        logic         srdy;
        logic         out_hs;
        string        tag;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt = 32'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: drive, push expectation, check at negedge, advance past posedge.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] s,
                       input logic sv, input logic r,
                       input logic [N-1:0] er, input logic ev, input logic esr,
                       input string tag);
        exp_t e;
        exp_t o;
        bus.valid_i     = v;
        bus.sel_i       = s;
        bus.sel_valid_i = sv;
        bus.ready_i     = r;
        e.rdy    = er;
        e.vld    = ev;
        e.srdy   = esr;
        e.out_hs = ev & r;
        e.tag    = tag;
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        total++;
        assert (bus.ready_o === o.rdy) else begin
            bad++;
            $error("FAIL %s ready_o got=%b exp=%b", o.tag, bus.ready_o, o.rdy);
        end
        total++;
        assert (bus.valid_o === o.vld) else begin
            bad++;
            $error("FAIL %s valid_o got=%b exp=%b", o.tag, bus.valid_o, o.vld);
        end
        total++;
        assert (bus.sel_ready_o === o.srdy) else begin
            bad++;
            $error("FAIL %s sel_ready_o got=%b exp=%b", o.tag, bus.sel_ready_o, o.srdy);
        end
        total++;
        assert (bus.join_cnt_o === exp_cnt) else begin
            bad++;
            $error("FAIL %s join_cnt_o got=%h exp=%h", o.tag, bus.join_cnt_o, exp_cnt);
        end
        $display("step %-12s v=%b s=%b sv=%b r=%b rst=%b -> ready_o=%b valid_o=%b sel_ready_o=%b cnt=%0d",
                 o.tag, v, s, sv, r, rst, bus.ready_o, bus.valid_o, bus.sel_ready_o, bus.join_cnt_o);
        @(posedge clk);
        if (rst) begin
            exp_cnt = 32'd0;
        end else if (o.out_hs) begin
`ifdef STREAM_JOIN_DYNAMIC_CNT_EN
            exp_cnt = exp_cnt + 32'd1;
`endif
        end
        #1;
    endtask

    initial begin
        bus.valid_i     = '0;
        bus.sel_i       = '0;
        bus.sel_valid_i = 1'b0;
        bus.ready_i     = 1'b0;

        // Reset with mask invalid: all outputs low.
        rst = 1'b1;
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "reset0");
        cyc(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "reset1");
        rst = 1'b0;

        // Zero-latency full join; arrived must stay clear afterwards.
        cyc(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, "full_join");
        cyc(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "full_clear");
        cyc(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, "full_join2");

        // Mask 0101: input 0 early, input 2 three cycles later.
        cyc(4'b0001, 4'b0101, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, "m0101_c0");
        cyc(4'b0000, 4'b0101, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, "m0101_c1");
        cyc(4'b0000, 4'b0101, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, "m0101_c2");
        cyc(4'b0100, 4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, "m0101_c3");

        // Mask 0011 with output backpressure for 5 cycles.
        cyc(4'b0011, 4'b0011, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, "bp_c0");
        for (int k = 1; k < 5; k++)
            cyc(4'b0000, 4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, $sformatf("bp_c%0d", k));
        cyc(4'b0000, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, "bp_done");

        // Empty mask: valid immediately, completes on ready_i alone.
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "empty_wait");
        cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, "empty_done");

        // Reset mid-join discards arrived inputs 0 and 1.
        cyc(4'b0011, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "mid_arrive");
        cyc(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, "mid_hold");
        rst = 1'b1;
        cyc(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, "mid_reset");
        rst = 1'b0;
        cyc(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "post_reset");
        cyc(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, "post_join");

        // Mask invalid: everything low, arrived bit 0 held across the gap.
        cyc(4'b0001, 4'b0011, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, "hold_arr");
        cyc(4'b0000, 4'b0011, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "hold_svlow");
        cyc(4'b0000, 4'b0011, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, "hold_back");
        cyc(4'b0010, 4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, "hold_done");

`ifdef STREAM_JOIN_DYNAMIC_CNT_EN
        // Counter wrap from all ones to zero.
        dut.r_join_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        cyc(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, "cnt_wrap");
`endif
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_join_dynamic.md
STREAM_JOIN_DYNAMIC -- requirements
Module: stream_join_dynamic

Interface
REQ-001: Parameter N_INP, default 0, number of input streams; the block SHALL stop elaboration with a fatal error when N_INP < 1.
REQ-002: clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003: rst_i  input  1  reset, synchronous and active-high.
REQ-004: valid_i  input  N_INP  per-input-stream valid.
REQ-005: ready_o  output  N_INP  per-input-stream ready.
REQ-006: sel_i  input  N_INP  join mask; bit i set means input i takes part in the current join.
REQ-007: sel_valid_i  input  1  join mask valid.
REQ-008: sel_ready_o  output  1  join mask ready.
REQ-009: valid_o  output  1  joined output stream valid.
REQ-010: ready_i  input  1  joined output stream ready.
REQ-011: join_cnt_o  output  32  count of completed joins; see Configuration.

Function
REQ-012: Handshake only, no data ports; the block SHALL hold an N_INP-bit arrived register, arrived_q.
REQ-013: ready_o[i] SHALL equal sel_valid_i & sel_i[i] & ~arrived_q[i], and SHALL NOT depend on ready_i.
REQ-014: An input handshake (valid_i[i] & ready_o[i]) SHALL set arrived_q[i] at the next edge unless an output handshake occurs in the same cycle.
REQ-015: Each selected input SHALL handshake exactly once per join; unselected inputs SHALL never see ready_o high.
REQ-016: valid_o SHALL equal sel_valid_i & AND over i of (~sel_i[i] | arrived_q[i] | valid_i[i]).
REQ-017: This gives zero-cycle latency: if all selected inputs are valid in one cycle with ready_i high, inputs, mask and output SHALL all handshake in that cycle.
REQ-018: sel_ready_o SHALL equal valid_o & ready_i, so the mask is consumed exactly on the output handshake.
REQ-019: On the output handshake, arrived_q SHALL clear to all zeros at the next edge, taking precedence over any same-cycle set.
REQ-020: If valid_o is high and ready_i is low, valid_o SHALL stay high; arrived bits SHALL persist and inputs already arrived SHALL see ready_o low.
REQ-021: Empty mask: when sel_valid_i is high and sel_i == 0, valid_o SHALL assert immediately and the join SHALL complete on ready_i with no input handshake.
REQ-022: When sel_valid_i is low, ready_o, valid_o and sel_ready_o SHALL all be 0, and arrived_q SHALL hold.
REQ-023: sel_i SHALL be held stable by the upstream while sel_valid_i is high and sel_ready_o is low; behaviour is undefined otherwise.
REQ-024: A simulation-only assertion SHALL flag any change of sel_i during that window.
REQ-025: A simulation-only assertion SHALL flag a valid_i[i] drop before its handshake.

Reset
REQ-026: While rst_i is high at a clock edge, arrived_q SHALL become 0 and join_cnt_o SHALL become 0.
REQ-027: Reset mid-join SHALL discard all arrived bits; after reset, every selected input SHALL handshake again.
REQ-028: Outputs SHALL be purely combinational from arrived_q and the inputs, so during reset, with sel_valid_i low, all outputs SHALL read 0.

Configuration
REQ-029: Macro STREAM_JOIN_DYNAMIC_CNT_EN SHALL control the join counter.
REQ-030: When the macro is defined, join_cnt_o SHALL increment by 1 on every output handshake and wrap modulo 2^32 (0xFFFFFFFF to 0).
REQ-031: When the macro is not defined, join_cnt_o SHALL be tied to 0 and no counter register SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-032: N_INP=4, sel_i=4'b1111, all valid_i high, ready_i high in one cycle -> all 4 inputs, the mask and the output handshake in that cycle; arrived_q stays 0.
REQ-033: N_INP=4, sel_i=4'b0101; valid_i[0] in cycle 0, valid_i[2] in cycle 3, ready_i always high -> ready_o[0] low in cycles 1-3; valid_o and sel_ready_o high only in cycle 3; ready_o[1] and ready_o[3] never high.
REQ-034: sel_i=4'b0011, both inputs handshake, ready_i low for 5 cycles -> valid_o high for 5 cycles, ready_o low, then completes on the cycle ready_i rises.
REQ-035: sel_i=0 with sel_valid_i high and ready_i high -> valid_o and sel_ready_o high in the same cycle; ready_o stays 0.
REQ-036: sel_i=4'b1111 with inputs 0 and 1 arrived, then rst_i high for 1 cycle -> arrived_q=0; after reset, inputs 0 and 1 again see ready_o high.
REQ-037: With the macro defined, 3 joins -> join_cnt_o=3; with the counter preloaded to 0xFFFFFFFF, one join -> 0; without the macro, join_cnt_o stays 0 throughout.
